// File: rtl/preg_free_list.sv
// Physical-register free list: ring of unallocated preg numbers with two-wide allocate,
// two-wide reclaim and per-branch-tag checkpoints of the allocation (head) pointer.
module preg_free_list #(
  parameter int unsigned NUM_PREGS              = 64,
  parameter int unsigned MAX_PREDICT_DEPTH      = 4,
  parameter int unsigned MAX_PREDICT_DEPTH_BITS = 3,
  localparam int unsigned PW                    = $clog2(NUM_PREGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_en,
  input  logic [1:0]                        alloc_num,
  output logic                              alloc_stall,
  output logic [PW-1:0]                     preg1,
  output logic [PW-1:0]                     preg2,
  output logic [PW:0]                       free_count,
  input  logic                              free1,
  input  logic [PW-1:0]                     free1_addr,
  input  logic                              free2,
  input  logic [PW-1:0]                     free2_addr,
  input  logic                              ckpt_en,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] ckpt_tag,
  input  logic                              freelist_branch_shootdown,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] freelist_shootdown_branch_tag,
  output logic                              err
);

  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;
  localparam int unsigned TB = MAX_PREDICT_DEPTH_BITS;
  localparam logic [TB-1:0] MaxTag  = TB'(MAX_PREDICT_DEPTH);
  localparam logic [CW-1:0] MaxFill = CW'(NUM_PREGS - 1);

  logic [PW-1:0] mem_q [NUM_PREGS];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] ckpt_head_q [MAX_PREDICT_DEPTH];
  logic [MAX_PREDICT_DEPTH-1:0] ckpt_valid_q, ckpt_valid_d;
  logic          err_q, err_d;

  logic [PW-1:0] head_idx1;
  logic          sd_tag_ok, ckpt_tag_ok;
  logic [IW-1:0] sd_idx, ckpt_idx;
  logic          ckpt_wr;
  logic [CW-1:0] count_after;
  logic          push1, push2;
  logic [PW-1:0] wr1_idx, wr2_idx;

  assign free_count  = tail_q - head_q;
  assign head_idx1   = head_q[PW-1:0] + PW'(1);
  assign preg1       = mem_q[head_q[PW-1:0]];
  assign preg2       = mem_q[head_idx1];
  assign alloc_stall = (CW'(alloc_num) > free_count) || freelist_branch_shootdown;
  assign err         = err_q;

  assign sd_tag_ok   = (freelist_shootdown_branch_tag != '0) &&
                       (freelist_shootdown_branch_tag <= MaxTag);
  assign ckpt_tag_ok = (ckpt_tag != '0) && (ckpt_tag <= MaxTag);
  assign sd_idx      = IW'(freelist_shootdown_branch_tag - TB'(1));
  assign ckpt_idx    = IW'(ckpt_tag - TB'(1));

  // Head side: shootdown takes priority and suppresses allocation and checkpointing.
  always_comb begin
    head_d       = head_q;
    ckpt_valid_d = ckpt_valid_q;
    ckpt_wr      = 1'b0;
    err_d        = err_q;
    if (freelist_branch_shootdown) begin
      if (sd_tag_ok && ckpt_valid_q[sd_idx]) begin
        head_d = ckpt_head_q[sd_idx];
        for (int unsigned k = 0; k < MAX_PREDICT_DEPTH; k++) begin
          if (k >= 32'(sd_idx)) ckpt_valid_d[k] = 1'b0;
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      if (alloc_en && !alloc_stall) begin
        if (alloc_num == 2'd3) err_d = 1'b1;
        else                   head_d = head_q + CW'(alloc_num);
      end
      if (ckpt_en) begin
        if (ckpt_tag_ok) begin
          ckpt_wr                = 1'b1;
          ckpt_valid_d[ckpt_idx] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Tail side: occupancy is judged after this cycle's head movement.
    count_after = tail_q - head_d;
    push1 = free1 && (free1_addr != '0) && (count_after < MaxFill);
    push2 = free2 && (free2_addr != '0) && ((count_after + CW'(push1)) < MaxFill);
    if ((free1 && !push1) || (free2 && !push2)) err_d = 1'b1;
    wr1_idx = tail_q[PW-1:0];
    wr2_idx = tail_q[PW-1:0] + PW'(push1);
    tail_d  = tail_q + CW'(push1) + CW'(push2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= MaxFill;
      ckpt_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      ckpt_valid_q <= ckpt_valid_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < MAX_PREDICT_DEPTH; k++) ckpt_head_q[k] <= '0;
    end else if (ckpt_wr) begin
      ckpt_head_q[ckpt_idx] <= head_d;
    end
  end

  // Preg 0 is never handed out, so the list initially holds 1..NUM_PREGS-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        mem_q[i] <= (i < NUM_PREGS - 1) ? PW'(i + 1) : '0;
      end
    end else begin
      if (push1) mem_q[wr1_idx] <= free1_addr;
      if (push2) mem_q[wr2_idx] <= free2_addr;
    end
  end

endmodule
